// File: rtl/serial_bus_master.sv
// Serial bus initiator: arbitrates, shifts a 15-bit address LSB-first, then 8 write bits out or 8 read bits in.
// Optional ACK timeout (ACK_WAIT cycles in AACK/DACK) is built only when BUS_MASTER_TIMEOUT_EN is defined.
module serial_bus_master #(
   parameter int ACK_WAIT = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        M_REQ,
   input  logic        M_RW,
   input  logic [14:0] M_ADDR,
   input  logic [7:0]  M_DIN,
   output logic        M_BUSY,
   output logic        M_DVALID,
   output logic [7:0]  M_DOUT,
   output logic        M_DONE,
   output logic        M_ERR,
   output logic        B_REQ,
   input  logic        B_GRANT,
   output logic        B_VALID,
   output logic        B_BUS_OUT,
   input  logic        B_BUS_IN,
   output logic        B_RW,
   input  logic        B_ACK,
   input  logic        B_SBSY,
   input  logic        B_READY
);

   typedef enum logic [2:0] {IDLE, ARB, ADDR, AACK, WDATA, DACK, RDATA, FINISH} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rw_q, rw_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  din_q, din_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  dout_d;
   logic        busy_d, dvalid_d, done_d, err_d;
   logic        b_req_d, b_valid_d, b_bus_out_d, b_rw_d;
   logic        timeout;

   // Slave status lines are observed by the system but never steer this FSM.
   logic monitor_unused;
   assign monitor_unused = B_SBSY | B_READY;

`ifdef BUS_MASTER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(ACK_WAIT + 1);

   logic [WAIT_W-1:0] wait_q, wait_d;

   assign timeout = !B_ACK && (wait_q == WAIT_W'(ACK_WAIT - 1));
   assign wait_d  = (state_d != state_q) ? '0 : wait_q + 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) wait_q <= '0;
      else     wait_q <= wait_d;
   end
`else
   logic ack_wait_unused;
   assign ack_wait_unused = (ACK_WAIT != 0);
   assign timeout         = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rdata_d  = rdata_q;
      dout_d   = M_DOUT;
      dvalid_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (M_REQ) begin
               state_d = ARB;
               rw_d    = M_RW;
               addr_d  = M_ADDR;
               din_d   = M_DIN;
            end
         end
         ARB:   if (B_GRANT) state_d = ADDR;
         ADDR:  if (cnt_q == 4'd14) state_d = AACK;
         AACK: begin
            if (B_ACK) begin
               state_d = rw_q ? WDATA : RDATA;
            end else if (timeout) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end
         end
         WDATA: if (cnt_q == 4'd7) state_d = DACK;
         DACK: begin
            if (B_ACK) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else if (timeout) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end
         end
         RDATA: begin
            // First RDATA cycle is a turnaround; bits arrive on counts 1..8.
            if (cnt_q != 4'd0) begin
               rdata_d = {B_BUS_IN, rdata_q[7:1]};
               if (cnt_q == 4'd8) begin
                  state_d  = FINISH;
                  dout_d   = rdata_d;
                  dvalid_d = 1'b1;
                  done_d   = 1'b1;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cnt_d = (state_d != state_q) ? 4'd0 :
              (cnt_q == 4'hF)      ? cnt_q : cnt_q + 4'd1;

      busy_d    = (state_d != IDLE);
      b_valid_d = state_d inside {ADDR, AACK, WDATA, DACK, RDATA};
      b_req_d   = b_valid_d || (state_d == ARB);
      b_rw_d    = b_valid_d && rw_d;

      b_bus_out_d = 1'b0;
      if (state_d == ADDR)       b_bus_out_d = addr_d[cnt_d];
      else if (state_d == WDATA) b_bus_out_d = din_d[cnt_d[2:0]];
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples the same pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         rdata_q   <= '0;
         M_BUSY    <= 1'b0;
         M_DVALID  <= 1'b0;
         M_DOUT    <= 8'h00;
         M_DONE    <= 1'b0;
         M_ERR     <= 1'b0;
         B_REQ     <= 1'b0;
         B_VALID   <= 1'b0;
         B_BUS_OUT <= 1'b0;
         B_RW      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         rdata_q   <= rdata_d;
         M_BUSY    <= busy_d;
         M_DVALID  <= dvalid_d;
         M_DOUT    <= dout_d;
         M_DONE    <= done_d;
         M_ERR     <= err_d;
         B_REQ     <= b_req_d;
         B_VALID   <= b_valid_d;
         B_BUS_OUT <= b_bus_out_d;
         B_RW      <= b_rw_d;
      end
   end

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: a timed slave/arbiter model drives frames, expected results are
// queued per transaction and an independent monitor compares them when M_DONE or M_ERR pulses.
module tb_serial_bus_master;

   localparam int ACK_WAIT = 15;
`ifdef BUS_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        M_REQ, M_RW;
   logic [14:0] M_ADDR;
   logic [7:0]  M_DIN;
   logic        M_BUSY, M_DVALID, M_DONE, M_ERR;
   logic [7:0]  M_DOUT;
   logic        B_REQ, B_GRANT, B_VALID, B_BUS_OUT, B_BUS_IN, B_RW, B_ACK, B_SBSY, B_READY;

   serial_bus_master #(.ACK_WAIT(ACK_WAIT)) dut (
      .CLK(CLK), .RST(RST),
      .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_DIN(M_DIN),
      .M_BUSY(M_BUSY), .M_DVALID(M_DVALID), .M_DOUT(M_DOUT), .M_DONE(M_DONE), .M_ERR(M_ERR),
      .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_VALID(B_VALID), .B_BUS_OUT(B_BUS_OUT),
      .B_BUS_IN(B_BUS_IN), .B_RW(B_RW), .B_ACK(B_ACK), .B_SBSY(B_SBSY), .B_READY(B_READY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int           c_c;     // capture cycle
      int           g_c;     // grant cycle
      int           end_c;   // FINISH cycle (M_DONE / M_ERR visible)
      bit           err;
      bit           dvalid;
      logic [7:0]   dout;
      bit           rw;
      logic [127:0] bits;    // B_BUS_OUT for every B_VALID cycle
      int           nbits;
   } exp_t;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         exp_done = 0;
   int         got_done = 0;
   logic [7:0] last_dout = 8'h00;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic [127:0] got_bits;
   int           got_n, valid_rise, req_rise, req_cnt, busy_cnt;
   bit           rw_and, rw_or;

   task automatic clear_frame();
      got_bits   = '0;
      got_n      = 0;
      valid_rise = -1;
      req_rise   = -1;
      req_cnt    = 0;
      busy_cnt   = 0;
      rw_and     = 1'b1;
      rw_or      = 1'b0;
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (RST) begin
         clear_frame();
      end else begin
         if (B_REQ) begin
            if (req_rise < 0) req_rise = cyc;
            req_cnt++;
         end
         if (M_BUSY) busy_cnt++;
         if (B_VALID) begin
            if (valid_rise < 0) valid_rise = cyc;
            if (got_n < 128) got_bits[7'(got_n)] = B_BUS_OUT;
            got_n++;
            rw_and &= B_RW;
            rw_or  |= B_RW;
         end else begin
            check("rw_outside_frame", 128'(B_RW), 128'(0));
         end
         check("dvalid_without_done", 128'(M_DVALID & ~M_DONE), 128'(0));
         if (M_DONE || M_ERR) begin
            if (M_DONE) got_done++;
            check("end_has_expect", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("end_cycle",   128'(cyc),        128'(e.end_c));
               check("done_pulse",  128'(M_DONE),     128'(!e.err));
               check("err_pulse",   128'(M_ERR),      128'(e.err));
               check("dvalid",      128'(M_DVALID),   128'(e.dvalid));
               check("dout",        128'(M_DOUT),     128'(e.dout));
               check("bus_release", 128'({B_VALID, B_REQ}), 128'(0));
               check("req_rise",    128'(req_rise),   128'(e.c_c + 1));
               check("valid_rise",  128'(valid_rise), 128'(e.g_c + 1));
               check("req_len",     128'(req_cnt),    128'(e.end_c - e.c_c - 1));
               check("busy_len",    128'(busy_cnt),   128'(e.end_c - e.c_c));
               check("frame_len",   128'(got_n),      128'(e.nbits));
               check("frame_bits",  got_bits,         e.bits);
               check("frame_rw",    128'({rw_and, rw_or}), 128'({e.rw, e.rw}));
            end
            clear_frame();
         end
      end
   end

   // ---------------- stimulus / slave model ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic noise();
      B_SBSY  = 1'($urandom);
      B_READY = 1'($urandom);
   endtask

   task automatic client_during_frame(input bit hold_req, input bit pulse_req);
      M_REQ  = hold_req ? 1'b1 : (pulse_req ? ((cyc % 5) == 0) : 1'b0);
      M_RW   = 1'($urandom);
      M_ADDR = 15'($urandom);
      M_DIN  = 8'($urandom);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         M_REQ    = 1'b0;
         B_GRANT  = 1'($urandom);
         B_ACK    = 1'($urandom);
         B_BUS_IN = 1'($urandom);
         noise();
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ctrl"}, 128'({M_BUSY, M_DVALID, M_DONE, M_ERR, B_REQ, B_VALID, B_BUS_OUT, B_RW}), 128'(0));
      check({tag, "_dout"}, 128'(M_DOUT), 128'(0));
   endtask

   // One complete frame. adel/ddel: wait cycles before the slave acknowledges address/data.
   task automatic do_txn(input bit rw, input logic [14:0] addr, input logic [7:0] din,
                         input int gdel, input int adel, input int ddel, input logic [7:0] rdata,
                         input bit hold_req, input bit pulse_req);
      exp_t e;
      int   c, g, ee, a, d, ack_d, endc, n;
      bit   to_a, to_d;
      tick();
      M_REQ = 1'b1; M_RW = rw; M_ADDR = addr; M_DIN = din;
      B_GRANT = 1'b0; B_ACK = 1'($urandom); B_BUS_IN = 1'($urandom); noise();
      c = cyc;
      for (int i = 0; i < gdel; i++) begin
         tick();
         client_during_frame(hold_req, pulse_req);
         B_GRANT = 1'b0; B_ACK = 1'($urandom); B_BUS_IN = 1'($urandom); noise();
      end
      tick();
      client_during_frame(hold_req, pulse_req);
      B_GRANT = 1'b1; B_ACK = 1'($urandom); B_BUS_IN = 1'($urandom); noise();
      g = cyc;

      // Frame schedule from the protocol rules: 15 address cycles, then the AACK wait.
      ee    = g + 16;
      to_a  = TO_EN && (adel >= ACK_WAIT);
      to_d  = 1'b0;
      a     = to_a ? -1 : ee + adel;
      d     = -1;
      ack_d = -1;
      if (to_a) endc = ee + ACK_WAIT;
      else if (!rw) endc = a + 10;
      else begin
         d    = a + 9;
         to_d = TO_EN && (ddel >= ACK_WAIT);
         if (to_d) endc = d + ACK_WAIT;
         else begin
            ack_d = d + ddel;
            endc  = ack_d + 1;
         end
      end

      e.c_c    = c;
      e.g_c    = g;
      e.end_c  = endc;
      e.err    = to_a || to_d;
      e.dvalid = !rw && !to_a;
      e.rw     = rw;
      e.bits   = '0;
      n = 0;
      for (int k = 0; k < 15; k++) begin
         e.bits[7'(n)] = addr[4'(k)];
         n++;
      end
      if (to_a) n += ACK_WAIT;
      else begin
         n += adel + 1;
         if (rw) begin
            for (int k = 0; k < 8; k++) begin
               e.bits[7'(n)] = din[3'(k)];
               n++;
            end
            n += to_d ? ACK_WAIT : ddel + 1;
         end else begin
            n += 9;
         end
      end
      e.nbits = n;
      if (e.dvalid) last_dout = rdata;
      e.dout = last_dout;
      if (!e.err) exp_done++;
      sb_q.push_back(e);

      for (int m = g + 1; m <= endc; m++) begin
         tick();
         client_during_frame(hold_req, pulse_req);
         B_GRANT = 1'($urandom);
         noise();
         if (a >= 0 && m == a)                                         B_ACK = 1'b1;
         else if (m >= ee && m < ((a >= 0) ? a : endc))                B_ACK = 1'b0;
         else if (ack_d >= 0 && m == ack_d)                            B_ACK = 1'b1;
         else if (d >= 0 && m >= d && m < ((ack_d >= 0) ? ack_d : endc)) B_ACK = 1'b0;
         else                                                          B_ACK = 1'($urandom);
         if (!rw && a >= 0 && m >= a + 2 && m <= a + 9) B_BUS_IN = rdata[3'(m - a - 2)];
         else                                           B_BUS_IN = 1'($urandom);
      end
   endtask

   task automatic reset_mid_frame();
      tick();
      M_REQ = 1'b1; M_RW = 1'b1; M_ADDR = 15'h2AAA; M_DIN = 8'h5A; B_GRANT = 1'b0;
      tick();
      M_REQ = 1'b0; B_GRANT = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         B_GRANT = 1'b0;
         B_ACK   = 1'($urandom);
      end
      // Address bit 7 is on the bus in this cycle.
      check("pre_rst_valid", 128'(B_VALID), 128'(1));
      RST = 1'b1;
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check_reset_values("mid_frame_rst");
      last_dout = 8'h00;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      bit rw, hold, pulse;
      int gd, ad, dd;
      RST = 1'b1; M_REQ = 1'b0; M_RW = 1'b0; M_ADDR = '0; M_DIN = '0;
      B_GRANT = 1'b0; B_BUS_IN = 1'b0; B_ACK = 1'b0; B_SBSY = 1'b0; B_READY = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check_reset_values("reset");

      do_txn(1'b1, 15'h1234, 8'hA5, 0, 0, 0, 8'h00, 1'b0, 1'b0);   // basic write
      gap(2);
      do_txn(1'b0, 15'h0007, 8'h00, 0, 0, 0, 8'h3C, 1'b0, 1'b0);   // basic read
      gap(2);
      do_txn(1'b1, 15'h5555, 8'h0F, 5, 1, 2, 8'h00, 1'b0, 1'b0);   // grant delayed 5
      gap(1);
      do_txn(1'b0, 15'h7ABC, 8'h00, 0, 20, 0, 8'h99, 1'b0, 1'b0);  // no address ACK within ACK_WAIT
      gap(1);
      do_txn(1'b1, 15'h0F0F, 8'hC3, 1, 0, 17, 8'h00, 1'b0, 1'b0);  // no data ACK within ACK_WAIT
      gap(2);
      reset_mid_frame();
      do_txn(1'b1, 15'h4321, 8'h96, 0, 0, 0, 8'h00, 1'b0, 1'b0);
      gap(2);
      do_txn(1'b1, 15'h1111, 8'h22, 1, 0, 0, 8'h00, 1'b1, 1'b0);   // M_REQ held: back-to-back
      do_txn(1'b0, 15'h3333, 8'h44, 0, 1, 0, 8'h5E, 1'b0, 1'b1);   // M_REQ pulsed mid-frame
      gap(3);

      for (int t = 0; t < 40; t++) begin
         rw    = 1'($urandom);
         gd    = $urandom_range(0, 4);
         ad    = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         dd    = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
         hold  = (t < 39) && ($urandom_range(0, 3) == 0);
         pulse = !hold && 1'($urandom);
         do_txn(rw, 15'($urandom), 8'($urandom), gd, ad, dd, 8'($urandom), hold, pulse);
         if (!hold) gap($urandom_range(0, 3));
      end

      gap(5);
      check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
      check("done_count", 128'(got_done), 128'(exp_done));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
